pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//   Producer side of the program-counter redirect interface. Arbitrates control-flow
//   redirects from execute (branch/jump), trap entry and mret, and drives the PC's
//   in/in_valid/flush inputs with a registered valid/ready handshake. After each
//   accepted redirect it asserts a squash window that kills wrong-path fetches in IF/ID.
// PARAMETERS
//   RESET_PC       32'h4000_0000  value of pc_in and held target after reset (never issued)
//   SQUASH_CYCLES  2              cycles of squash after handshake (0..15); 0 = no window
//   TRAP_VECTOR    32'h4000_0100  redirect target for misaligned-target exception
// PORTS
//   clk                 in   1   clock, all state on rising edge
//   rst                 in   1   asynchronous, active-high reset
//   pc_ready            in   1   PC/fetch side accepts redirect this cycle
//   ex_redirect_valid   in   1   execute-stage taken branch / jump
//   ex_redirect_target  in   32  execute redirect target
//   trap_valid          in   1   trap entry request
//   trap_target         in   32  trap handler address (mtvec)
//   mret_valid          in   1   mret request
//   mret_target         in   32  return address (mepc)
//   pc_in_valid         out  1   redirect valid (registered)
//   pc_in               out  32  redirect target (registered)
//   pc_flush            out  1   equals pc_in_valid; PC gives flush priority over stall
//   squash              out  1   kill IF/ID instructions this cycle
//   busy                out  1   state != IDLE
//   redirect_count      out  32  accepted redirects, wraps 32'hFFFF_FFFF -> 0
//   misalign_exc        out  1   one-cycle pulse: misaligned target detected
//   misalign_addr       out  32  offending target, held until next detection
// BEHAVIOUR
//   - Reset: state IDLE; pc_in_valid, pc_flush, squash, busy, misalign_exc = 0;
//     pc_in = RESET_PC; redirect_count = 0; misalign_addr = 0; squash counter = 0.
//     Asserting rst mid-operation discards any held redirect immediately.
//   - Priority, same cycle: trap (2) > mret (1) > ex (0); losers dropped, not queued.
//   - States: IDLE, ISSUE, SQUASH.
//     IDLE: winning request at edge N -> ISSUE. pc_in_valid = pc_flush = 1 from cycle N+1.
//     ISSUE: pc_in_valid, pc_flush, squash high. pc_in stable until handshake.
//       Handshake = pc_in_valid && pc_ready at an edge.
//       New request with prio >= held prio replaces pc_in/held prio; valid stays high.
//       Lower prio is dropped. On handshake without replacement, count += 1; go to
//       SQUASH with counter = SQUASH_CYCLES, or to IDLE if SQUASH_CYCLES == 0.
//       On handshake with same-edge replacement, count += 1; stay in ISSUE with the new target.
//     SQUASH: squash = 1, pc_in_valid = 0; counter decrements each cycle; at 1 -> IDLE.
//       Any request goes to ISSUE (counter abandoned; squash stays high).
//   - squash high for exactly SQUASH_CYCLES cycles after handshake cycle, plus all ISSUE cycles.
//   - Held priority tracked as 2-bit register; cleared to 0 on leaving ISSUE.
// CONFIGURATION
//   REDIRECT_ALIGN_CHECK_EN defined: any winning target with [1:0] != 0 is replaced by
//     TRAP_VECTOR; misalign_exc pulses for 1 cycle, coincident with ISSUE entry;
//     misalign_addr <= original target; replacement carries trap priority (2).
//   Undefined: target[1:0] forced to 2'b00; misalign_exc tied 0; misalign_addr tied 0.
// TESTING
//   1 ex_redirect 0x4000_0040, pc_ready=1, SQUASH_CYCLES=2 -> pc_in_valid 1 cyc @N+1,
//     pc_in=0x4000_0040; squash 3 cyc; redirect_count=1; busy back to 0 @N+4.
//   2 ex 0x4000_0080 + trap 0x4000_0200 same cycle -> single issue of 0x4000_0200; count=1.
//   3 pc_ready=0 for 4 cycles; ex 0x4000_0010 then mret 0x4000_0300 while held
//     -> pc_in switches to 0x4000_0300, valid never drops; one handshake when ready rises.
//   4 held trap 0x4000_0200, ex 0x4000_0020 arrives -> ex dropped; pc_in stays 0x4000_0200.
//   5 rst asserted mid-ISSUE (async, between edges) -> outputs clear immediately;
//     count=0; no issue after release.
//   6 [EN] ex target 0x4000_0042 -> pc_in=TRAP_VECTOR, misalign_exc 1 cyc,
//     misalign_addr=0x4000_0042; [no EN] -> pc_in=0x4000_0040, misalign_exc=0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: producer side of the PC redirect interface.
// Arbitrates trap > mret > execute redirects and drives a registered valid/ready handshake
// into the PC. A squash window follows each accepted redirect to kill wrong-path IF/ID work.
// Optional feature macro: REDIRECT_ALIGN_CHECK_EN. When it is defined, a misaligned target
// is replaced by TRAP_VECTOR and reported. When it is undefined, the low target bits are cleared.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h4000_0000,
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter logic [31:0] TRAP_VECTOR   = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_ready,
  input  logic        ex_redirect_valid,
  input  logic [31:0] ex_redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  input  logic        mret_valid,
  input  logic [31:0] mret_target,
  output logic        pc_in_valid,
  output logic [31:0] pc_in,
  output logic        pc_flush,
  output logic        squash,
  output logic        busy,
  output logic [31:0] redirect_count,
  output logic        misalign_exc,
  output logic [31:0] misalign_addr
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = 2;

  localparam logic [PW-1:0] PRIO_EX   = PW'(0);
  localparam logic [PW-1:0] PRIO_MRET = PW'(1);
  localparam logic [PW-1:0] PRIO_TRAP = PW'(2);
  localparam logic [CW-1:0] SQ_INIT   = CW'(SQUASH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_in_q;
  logic          pc_in_valid_q;
  logic          squash_q;
  logic          busy_q;
  logic [AW-1:0] count_q;
  logic [AW-1:0] count_d;
  logic [PW-1:0] prio_q;
  logic [CW-1:0] sq_cnt_q;

  logic          win_valid;
  logic [PW-1:0] raw_prio;
  logic [AW-1:0] raw_target;
  logic [PW-1:0] win_prio;
  logic [AW-1:0] win_target;
  logic          win_misaligned;
  logic          take;
  logic          handshake;

  // Fixed-priority pick among the three request sources
  always_comb begin
    win_valid  = trap_valid | mret_valid | ex_redirect_valid;
    raw_prio   = PRIO_EX;
    raw_target = ex_redirect_target;
    if (trap_valid) begin
      raw_prio   = PRIO_TRAP;
      raw_target = trap_target;
    end else if (mret_valid) begin
      raw_prio   = PRIO_MRET;
      raw_target = mret_target;
    end
  end

`ifdef REDIRECT_ALIGN_CHECK_EN
  // Misaligned winners become a trap-priority redirect to TRAP_VECTOR
  always_comb begin
    win_misaligned = win_valid && (raw_target[1:0] != 2'b00);
    win_target     = win_misaligned ? TRAP_VECTOR : raw_target;
    win_prio       = win_misaligned ? PRIO_TRAP : raw_prio;
  end
`else
  // Without the check the target is simply word-aligned
  always_comb begin
    win_misaligned = 1'b0;
    win_target     = raw_target & ~AW'(3);
    win_prio       = raw_prio;
  end
`endif

  // Accept the winner unless a higher-priority redirect is already being held
  always_comb begin
    take      = win_valid && ((state_q != ST_ISSUE) || (win_prio >= prio_q));
    handshake = pc_in_valid_q && pc_ready;
    count_d   = count_q + AW'(1);
  end

  // Redirect FSM with registered handshake, squash and counter outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_in_q       <= RESET_PC;
      pc_in_valid_q <= 1'b0;
      squash_q      <= 1'b0;
      busy_q        <= 1'b0;
      count_q       <= '0;
      prio_q        <= '0;
      sq_cnt_q      <= '0;
    end else begin
      if (handshake) begin
        count_q <= count_d;
      end
      if (take) begin
        state_q       <= ST_ISSUE;
        pc_in_q       <= win_target;
        prio_q        <= win_prio;
        pc_in_valid_q <= 1'b1;
        squash_q      <= 1'b1;
        busy_q        <= 1'b1;
        sq_cnt_q      <= '0;
      end else begin
        case (state_q)
          ST_ISSUE: begin
            if (handshake) begin
              prio_q        <= '0;
              pc_in_valid_q <= 1'b0;
              if (SQUASH_CYCLES == 0) begin
                state_q  <= ST_IDLE;
                squash_q <= 1'b0;
                busy_q   <= 1'b0;
                sq_cnt_q <= '0;
              end else begin
                state_q  <= ST_SQUASH;
                squash_q <= 1'b1;
                busy_q   <= 1'b1;
                sq_cnt_q <= SQ_INIT;
              end
            end
          end
          ST_SQUASH: begin
            if (sq_cnt_q <= CW'(1)) begin
              state_q  <= ST_IDLE;
              squash_q <= 1'b0;
              busy_q   <= 1'b0;
              sq_cnt_q <= '0;
            end else begin
              sq_cnt_q <= sq_cnt_q - CW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef REDIRECT_ALIGN_CHECK_EN
  logic          misalign_exc_q;
  logic [AW-1:0] misalign_addr_q;

  // One-cycle report of a misaligned redirect, coincident with its ISSUE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_exc_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_exc_q <= take && win_misaligned;
      if (take && win_misaligned) begin
        misalign_addr_q <= raw_target;
      end
    end
  end

  assign misalign_exc  = misalign_exc_q;
  assign misalign_addr = misalign_addr_q;
`else
  assign misalign_exc  = 1'b0;
  assign misalign_addr = '0;
`endif

  assign pc_in_valid    = pc_in_valid_q;
  assign pc_flush       = pc_in_valid_q;
  assign pc_in          = pc_in_q;
  assign squash         = squash_q;
  assign busy           = busy_q;
  assign redirect_count = count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: a cycle-by-cycle vector table plus an async-reset sequence.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        pc_ready;
  logic        ex_redirect_valid;
  logic [31:0] ex_redirect_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        mret_valid;
  logic [31:0] mret_target;
  logic        pc_in_valid;
  logic [31:0] pc_in;
  logic        pc_flush;
  logic        squash;
  logic        busy;
  logic [31:0] redirect_count;
  logic        misalign_exc;
  logic [31:0] misalign_addr;

  int n_pass;
  int n_total;

`ifdef REDIRECT_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_PC   = 32'h4000_0100;
  localparam logic        MIS_EXC  = 1'b1;
  localparam logic [31:0] MIS_ADDR = 32'h4000_0042;
`else
  localparam logic [31:0] MIS_PC   = 32'h4000_0040;
  localparam logic        MIS_EXC  = 1'b0;
  localparam logic [31:0] MIS_ADDR = 32'h0000_0000;
`endif

  typedef struct {
    logic        rdy;
    logic        exv;
    logic [31:0] ext;
    logic        trv;
    logic [31:0] trt;
    logic        mrv;
    logic [31:0] mrt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_squash;
    logic        e_busy;
    logic [31:0] e_count;
    logic        e_mexc;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];

  pc_redirect_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .pc_ready           (pc_ready),
    .ex_redirect_valid  (ex_redirect_valid),
    .ex_redirect_target (ex_redirect_target),
    .trap_valid         (trap_valid),
    .trap_target        (trap_target),
    .mret_valid         (mret_valid),
    .mret_target        (mret_target),
    .pc_in_valid        (pc_in_valid),
    .pc_in              (pc_in),
    .pc_flush           (pc_flush),
    .squash             (squash),
    .busy               (busy),
    .redirect_count     (redirect_count),
    .misalign_exc       (misalign_exc),
    .misalign_addr      (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic void addv(input logic rdy, input logic exv, input logic [31:0] ext,
                               input logic trv, input logic [31:0] trt,
                               input logic mrv, input logic [31:0] mrt,
                               input logic ev, input logic [31:0] epc, input logic esq,
                               input logic eb, input logic [31:0] ec,
                               input logic emx, input logic [31:0] ema);
    vec_t v;
    v.rdy = rdy; v.exv = exv; v.ext = ext; v.trv = trv; v.trt = trt;
    v.mrv = mrv; v.mrt = mrt; v.e_valid = ev; v.e_pc = epc; v.e_squash = esq;
    v.e_busy = eb; v.e_count = ec; v.e_mexc = emx; v.e_maddr = ema;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rdy, input logic exv, input logic [31:0] ext,
                       input logic trv, input logic [31:0] trt,
                       input logic mrv, input logic [31:0] mrt);
    pc_ready = rdy; ex_redirect_valid = exv; ex_redirect_target = ext;
    trap_valid = trv; trap_target = trt; mret_valid = mrv; mret_target = mrt;
  endtask

  task automatic chk_outputs(input int idx, input logic ev, input logic [31:0] epc, input logic esq,
                             input logic eb, input logic [31:0] ec, input logic emx,
                             input logic [31:0] ema);
    chk("pc_in_valid", idx, 32'(pc_in_valid), 32'(ev));
    chk("pc_flush", idx, 32'(pc_flush), 32'(ev));
    chk("pc_in", idx, pc_in, epc);
    chk("squash", idx, 32'(squash), 32'(esq));
    chk("busy", idx, 32'(busy), 32'(eb));
    chk("redirect_count", idx, redirect_count, ec);
    chk("misalign_exc", idx, 32'(misalign_exc), 32'(emx));
    chk("misalign_addr", idx, misalign_addr, ema);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Basic ex redirect, immediate accept, 2-cycle squash tail
    addv(1, 1, 32'h4000_0040, 0, 0, 0, 0,  1, 32'h4000_0040, 1, 1, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0040, 1, 1, 1, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0040, 1, 1, 1, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0040, 0, 0, 1, 0, 0);
    // Same-cycle ex + trap: trap wins, single issue
    addv(1, 1, 32'h4000_0080, 1, 32'h4000_0200, 0, 0,  1, 32'h4000_0200, 1, 1, 1, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0200, 1, 1, 2, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0200, 1, 1, 2, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0200, 0, 0, 2, 0, 0);
    // Stalled ex replaced by mret while held; one handshake on ready
    addv(0, 1, 32'h4000_0010, 0, 0, 0, 0,  1, 32'h4000_0010, 1, 1, 2, 0, 0);
    addv(0, 0, 0, 0, 0, 1, 32'h4000_0300,  1, 32'h4000_0300, 1, 1, 2, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,              1, 32'h4000_0300, 1, 1, 2, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,              1, 32'h4000_0300, 1, 1, 2, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0300, 1, 1, 3, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0300, 1, 1, 3, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0300, 0, 0, 3, 0, 0);
    // Held trap ignores a later lower-priority ex
    addv(0, 0, 0, 1, 32'h4000_0200, 0, 0,  1, 32'h4000_0200, 1, 1, 3, 0, 0);
    addv(0, 1, 32'h4000_0020, 0, 0, 0, 0,  1, 32'h4000_0200, 1, 1, 3, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0200, 1, 1, 4, 0, 0);
    // Request during squash re-enters ISSUE; then handshake with same-edge replacement
    addv(0, 1, 32'h4000_0044, 0, 0, 0, 0,  1, 32'h4000_0044, 1, 1, 4, 0, 0);
    addv(1, 1, 32'h4000_0048, 0, 0, 0, 0,  1, 32'h4000_0048, 1, 1, 5, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0048, 1, 1, 6, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0048, 1, 1, 6, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,              0, 32'h4000_0048, 0, 0, 6, 0, 0);
    // Misaligned ex target
    addv(0, 1, 32'h4000_0042, 0, 0, 0, 0,  1, MIS_PC, 1, 1, 6, MIS_EXC, MIS_ADDR);
    addv(1, 0, 0, 0, 0, 0, 0,              0, MIS_PC, 1, 1, 7, 0, MIS_ADDR);
    addv(1, 0, 0, 0, 0, 0, 0,              0, MIS_PC, 1, 1, 7, 0, MIS_ADDR);
    addv(1, 0, 0, 0, 0, 0, 0,              0, MIS_PC, 0, 0, 7, 0, MIS_ADDR);

    // Reset values
    #12;
    chk_outputs(-1, 0, 32'h4000_0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rdy, vecs[i].exv, vecs[i].ext, vecs[i].trv, vecs[i].trt,
            vecs[i].mrv, vecs[i].mrt);
      @(posedge clk);
      #1;
      chk_outputs(i, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_squash, vecs[i].e_busy,
                  vecs[i].e_count, vecs[i].e_mexc, vecs[i].e_maddr);
    end

    // Async reset in the middle of a stalled ISSUE
    drive(0, 1, 32'h4000_0060, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 100, 32'(pc_in_valid), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs(101, 0, 32'h4000_0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_reset_valid", 102 + k, 32'(pc_in_valid), 32'd0);
      chk("post_reset_count", 102 + k, redirect_count, 32'd0);
      chk("post_reset_pc", 102 + k, pc_in, 32'h4000_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
